pixel_clk_supervisor: RTL and testbench

PIXEL_CLK_SUPERVISOR -- requirements
Module: pixel_clk_supervisor

---
 rtl/pixel_clk_supervisor.sv | 175 +++++++++++++++++
 tb/tb_pixel_clk_supervisor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_clk_supervisor.sv
// Pixel clock PLL supervisor.
//
// Sequences a PLL through reset, lock acquisition and a lock-stability window, then releases
// the per-domain resets one by one at a fixed stagger. Any loss of lock after release, or a
// soft reset request, drops every domain reset and restarts the PLL bring-up.
//
// Ports:
//   refclk          free-running reference clock, all logic on its rising edge
//   rst_n           asynchronous active-low reset
//   pll_locked      PLL lock indication, asynchronous to refclk
//   soft_reset      synchronous request to restart the bring-up sequence
//   pll_rst         active-high reset to the PLL
//   clk_rst_n       per-domain active-low resets, bit i for PLL output i
//   ready           all domains released and lock held
//   lock_loss_count saturating count of lock losses seen while running
//   timeout_err     sticky flag, set whenever lock acquisition times out
module pixel_clk_supervisor #(
  parameter int unsigned NUM_CLKS       = 1,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 65536
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                soft_reset,
  output logic                pll_rst,
  output logic [NUM_CLKS-1:0] clk_rst_n,
  output logic                ready,
  output logic [7:0]          lock_loss_count,
  output logic                timeout_err
);

  // One shared counter serves every state, so it is sized for the largest terminal count.
  localparam int unsigned MaxAb  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                    : STABLE_CYCLES;
  localparam int unsigned MaxCd  = (STAGGER_CYCLES > LOCK_TIMEOUT) ? STAGGER_CYCLES
                                                                   : LOCK_TIMEOUT;
  localparam int unsigned CntMax = (MaxAb > MaxCd) ? MaxAb : MaxCd;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);
  localparam logic [NUM_CLKS-1:0] FirstDomain = NUM_CLKS'(1);

  typedef enum logic [2:0] {
    StPllReset,
    StWaitLock,
    StStable,
    StRelease,
    StRun
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      sync_q;
  logic            locked_s;

  // Two-flop synchroniser; nothing downstream looks at pll_locked directly.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StPllReset;
      cnt_q           <= '0;
      pll_rst         <= 1'b1;
      clk_rst_n       <= '0;
      ready           <= 1'b0;
      lock_loss_count <= 8'd0;
      timeout_err     <= 1'b0;
    end else if (soft_reset) begin
      // Takes priority over everything, including a coincident lock loss, and restarts the
      // PLL reset pulse on every cycle it is held.
      state_q   <= StPllReset;
      cnt_q     <= '0;
      pll_rst   <= 1'b1;
      clk_rst_n <= '0;
      ready     <= 1'b0;
    end else begin
      unique case (state_q)
        StPllReset: begin
          if (cnt_q == RstLast) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StWaitLock: begin
          if (locked_s) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            state_q     <= StPllReset;
            cnt_q       <= '0;
            pll_rst     <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StStable: begin
          if (!locked_s) begin
            // Glitch: the stability window starts over, as does the lock timeout.
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q   <= StRelease;
            cnt_q     <= '0;
            clk_rst_n <= FirstDomain;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StRelease: begin
          if (!locked_s) begin
            state_q   <= StPllReset;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            clk_rst_n <= '0;
          end else if (cnt_q == StaggerLast) begin
            cnt_q <= '0;
            // Released bits form a thermometer code from bit 0 upward.
            if (&clk_rst_n) begin
              state_q <= StRun;
              ready   <= 1'b1;
            end else begin
              clk_rst_n <= (clk_rst_n << 1) | FirstDomain;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StRun: begin
          if (!locked_s) begin
            state_q   <= StPllReset;
            cnt_q     <= '0;
            pll_rst   <= 1'b1;
            clk_rst_n <= '0;
            ready     <= 1'b0;
            if (lock_loss_count != 8'hFF) begin
              lock_loss_count <= lock_loss_count + 8'd1;
            end
          end
        end

        default: begin
          state_q   <= StPllReset;
          cnt_q     <= '0;
          pll_rst   <= 1'b1;
          clk_rst_n <= '0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_clk_supervisor.sv
// Scoreboard bench for pixel_clk_supervisor. A reference model derives, from the stimulus
// waveform and elapsed time in each phase, every expected change of the output bundle and
// queues it with its cycle number; a monitor pops and compares whenever the DUT outputs change.
module tb_pixel_clk_supervisor;

  localparam int NCLK = 3;
  localparam int PRST = 4;
  localparam int STAB = 10;
  localparam int STAG = 2;
  localparam int TOUT = 20;
  localparam int MAXL = 8200;

  localparam int PhRst    = 0;
  localparam int PhWait   = 1;
  localparam int PhStable = 2;
  localparam int PhRel    = 3;
  localparam int PhRun    = 4;

  localparam logic [13:0] RstVal = 14'h2000;

  logic            clk;
  logic            rst_n;
  logic            pll_locked;
  logic            soft_reset;
  logic            pll_rst;
  logic [NCLK-1:0] clk_rst_n;
  logic            ready;
  logic [7:0]      lock_loss_count;
  logic            timeout_err;

  pixel_clk_supervisor #(
    .NUM_CLKS      (NCLK),
    .PLL_RST_CYCLES(PRST),
    .STABLE_CYCLES (STAB),
    .STAGGER_CYCLES(STAG),
    .LOCK_TIMEOUT  (TOUT)
  ) dut (
    .refclk         (clk),
    .rst_n          (rst_n),
    .pll_locked     (pll_locked),
    .soft_reset     (soft_reset),
    .pll_rst        (pll_rst),
    .clk_rst_n      (clk_rst_n),
    .ready          (ready),
    .lock_loss_count(lock_loss_count),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    int          cyc;
    logic [13:0] val;
  } ev_t;

  ev_t         sb[$];
  logic [13:0] last_exp;
  logic [13:0] last_seen;
  int          cyc;
  int          checks;
  int          errors;
  bit          lk [0:MAXL];
  bit          sr [0:MAXL];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] bundle();
    return {pll_rst, clk_rst_n, ready, timeout_err, lock_loss_count};
  endfunction

  // Monitor: every change of the output bundle must match the next queued expectation.
  always @(negedge clk) begin
    logic [13:0] cur;
    ev_t ev;
    cur = bundle();
    if (cur !== last_seen) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
      end else begin
        ev = sb.pop_front();
        if (ev.cyc != cyc || ev.val !== cur) begin
          errors++;
          $display("FAIL output_event got cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, cur, ev.cyc, ev.val);
        end
      end
      last_seen = cur;
    end
  end

  task automatic expect_at(input int c, input logic [13:0] v);
    ev_t ev;
    if (v !== last_exp) begin
      ev.cyc = c;
      ev.val = v;
      sb.push_back(ev);
      last_exp = v;
    end
  endtask

  // Reference model: walks the locked/soft-reset waveform, tracking only the current phase
  // and the cycle it began, and derives outputs from time elapsed in that phase.
  task automatic model_run(input int base, input int len, input int stop_bits,
                           output int used_len);
    int ph, e, lost, n, ls;
    bit to;
    logic [2:0] clkv;
    ph = PhRst; e = 0; lost = 0; to = 0;
    used_len = len;
    for (int k = 1; k <= len; k++) begin
      ls = (k >= 3) ? int'(lk[k-2]) : 0;
      if (sr[k]) begin
        ph = PhRst; e = k;
      end else begin
        case (ph)
          PhRst:    if (k - e == PRST) begin ph = PhWait; e = k; end
          PhWait:   if (ls != 0) begin ph = PhStable; e = k; end
                    else if (k - e == TOUT) begin to = 1; ph = PhRst; e = k; end
          PhStable: if (ls == 0) begin ph = PhWait; e = k; end
                    else if (k - e == STAB) begin ph = PhRel; e = k; end
          PhRel:    if (ls == 0) begin ph = PhRst; e = k; end
                    else if (k - e == NCLK * STAG) begin ph = PhRun; e = k; end
          default:  if (ls == 0) begin
                      ph = PhRst; e = k;
                      if (lost < 255) lost++;
                    end
        endcase
      end
      n = 0;
      if (ph == PhRun) n = NCLK;
      else if (ph == PhRel) begin
        n = (k - e) / STAG + 1;
        if (n > NCLK) n = NCLK;
      end
      clkv = 3'((1 << n) - 1);
      expect_at(base + k, {ph == PhRst, clkv, ph == PhRun, to, 8'(lost)});
      if (stop_bits > 0 && ph == PhRel && n == stop_bits) begin
        used_len = k;
        break;
      end
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k <= MAXL; k++) begin
      lk[k] = 1'b0;
      sr[k] = 1'b0;
    end
  endtask

  task automatic lock_from(input int first, input int len);
    for (int k = first; k <= len; k++) lk[k] = 1'b1;
  endtask

  // Resets the DUT between edges, checks the asynchronous effect, then plays the waveform.
  task automatic run_scenario(input int len, input int stop_bits);
    int base, used;
    logic [13:0] cur;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    soft_reset = 1'b0;
    pll_locked = 1'b0;
    expect_at(cyc + 1, RstVal);
    #1;
    cur = bundle();
    checks++;
    if (cur !== RstVal) begin
      errors++;
      $display("FAIL async_reset got=%h required=%h", cur, RstVal);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    base = cyc;
    rst_n = 1'b1;
    model_run(base, len, stop_bits, used);
    for (int k = 1; k <= used; k++) begin
      pll_locked = lk[k];
      soft_reset = sr[k];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_stim(input int len);
    bit lvl;
    int k, seg, np;
    lvl = 1'b0;
    k = 1;
    while (k <= len) begin
      seg = lvl ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 25));
      for (int j = 0; j < seg && k <= len; j++) begin
        lk[k] = lvl;
        k++;
      end
      lvl = !lvl;
    end
    for (int m = 1; m <= len; m++) begin
      if ($urandom_range(0, 79) == 0) begin
        np = int'($urandom_range(1, 3));
        for (int j = 0; j < np && m + j <= len; j++) sr[m+j] = 1'b1;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    last_exp = RstVal;
    last_seen = RstVal;
    rst_n = 1'b1;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    #1 rst_n = 1'b0;

    // Normal bring-up, lock at cycle 6.
    clear_stim(); lock_from(6, 50);
    run_scenario(50, 0);

    // One-cycle glitch after 7 stable cycles.
    clear_stim(); lock_from(6, 60); lk[14] = 1'b0;
    run_scenario(60, 0);

    // Lock loss in RUN, then soft reset coincident with a second loss, held 3 cycles.
    clear_stim(); lock_from(6, 100); lk[30] = 1'b0; lk[60] = 1'b0;
    sr[62] = 1'b1; sr[63] = 1'b1; sr[64] = 1'b1;
    run_scenario(100, 0);

    // Never locks: repeated timeouts and PLL reset pulses.
    clear_stim();
    run_scenario(80, 0);

    // Reset pulse mid-RELEASE once clk_rst_n reads 011.
    clear_stim(); lock_from(6, 100);
    run_scenario(100, 2);

    // 270 RUN lock losses to saturate the counter, then a soft reset coincident with a loss.
    clear_stim(); lock_from(3, 8160);
    for (int j = 1; j <= 270; j++) lk[30*j] = 1'b0;
    lk[8130] = 1'b0; sr[8132] = 1'b1;
    run_scenario(8160, 0);

    for (int r = 0; r < 6; r++) begin
      clear_stim();
      random_stim(300);
      run_scenario(300, 0);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
